// File: rtl/mux_n_1_pipe.sv
// Purpose : N:1 channel mux with a registered, valid/ready-handshaked output word.
// Latency : 1 cycle from acceptance to out_valid when the block is empty.
// Backpressure: the skid build holds two words and registers in_ready; the default build holds one word and in_ready passes out_ready through combinationally.
//
// Optional feature macro: MUX_N_1_PIPE_SKID_EN (defined = main + skid registers, registered in_ready).
//
// Ports:
//   clk        - the only clock, rising edge
//   rst        - asynchronous active-high reset
//   in_data    - N channels, channel i at [i*WIDTH +: WIDTH]
//   sel        - channel index, sampled with in_data
//   in_valid   - upstream offers in_data/sel
//   in_ready   - block can accept this cycle
//   out_data   - selected channel data (zero if sel >= N)
//   out_sel    - sel value travelling with out_data
//   out_err    - sel value travelling with out_data was >= N
//   out_valid  - out_data/out_sel/out_err are valid
//   out_ready  - downstream accepts this cycle
module mux_n_1_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SEL_W = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // One extra bit so that N itself is representable for the range check.
    localparam logic [SEL_W:0] N_L = (SEL_W+1)'(N);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   main_data;
    logic [SEL_W-1:0]   main_sel;
    logic               main_err;

    logic [WIDTH-1:0]   cap_data;
    logic               cap_err;
    logic               accept;

    // Out-of-range selects match no channel, so the captured data falls back to zero.
    always_comb begin
        cap_data = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                cap_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign cap_err   = ({1'b0, sel} >= N_L);
    assign accept    = in_valid & in_ready;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_sel   = main_sel;
    assign out_err   = main_err;

`ifdef MUX_N_1_PIPE_SKID_EN

    logic [WIDTH-1:0]   skid_data;
    logic [SEL_W-1:0]   skid_sel;
    logic               skid_err;

    // Depends only on state and rst, never on out_ready.
    assign in_ready = (state != TWO) & !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_data <= '0;
            main_sel  <= '0;
            main_err  <= 1'b0;
            skid_data <= '0;
            skid_sel  <= '0;
            skid_err  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data <= cap_data;
                        main_sel  <= sel;
                        main_err  <= cap_err;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !out_ready) begin
                        // Main is stalled: park the new word behind it.
                        skid_data <= cap_data;
                        skid_sel  <= sel;
                        skid_err  <= cap_err;
                        state     <= TWO;
                    end else if (accept && out_ready) begin
                        main_data <= cap_data;
                        main_sel  <= sel;
                        main_err  <= cap_err;
                    end else if (out_ready) begin
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        main_data <= skid_data;
                        main_sel  <= skid_sel;
                        main_err  <= skid_err;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`else

    // Single entry: space exists when empty or when the held word leaves this cycle.
    assign in_ready = (!out_valid | out_ready) & !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_data <= '0;
            main_sel  <= '0;
            main_err  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data <= cap_data;
                        main_sel  <= sel;
                        main_err  <= cap_err;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept) begin
                        main_data <= cap_data;
                        main_sel  <= sel;
                        main_err  <= cap_err;
                    end else if (out_ready) begin
                        state     <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_mux_n_1_pipe.sv
module tb_mux_n_1_pipe;

    localparam int WIDTH = 32;

`ifdef MUX_N_1_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // N=4 instance (scoreboarded)
    logic [4*WIDTH-1:0] in_data = '0;
    logic [1:0]         sel = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_err;
    logic               out_valid;
    logic               out_ready = 1'b0;

    // N=5 instance (out-of-range select checks)
    logic [5*WIDTH-1:0] in_data5 = '0;
    logic [2:0]         sel5 = '0;
    logic               in_valid5 = 1'b0;
    logic               in_ready5;
    logic [WIDTH-1:0]   out_data5;
    logic [2:0]         out_sel5;
    logic               out_err5;
    logic               out_valid5;
    logic               out_ready5 = 1'b0;

    mux_n_1_pipe #(.WIDTH(WIDTH), .N(4)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_n_1_pipe #(.WIDTH(WIDTH), .N(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_data(in_data5), .sel(sel5), .in_valid(in_valid5),
        .in_ready(in_ready5), .out_data(out_data5), .out_sel(out_sel5), .out_err(out_err5),
        .out_valid(out_valid5), .out_ready(out_ready5)
    );

    int checks   = 0;
    int failures = 0;

    // Expected words {data, sel, err}
    logic [34:0] sb[$];

    function automatic logic [31:0] ref_mux(input logic [127:0] d, input logic [1:0] s);
        case (s)
            2'd0:    return d[31:0];
            2'd1:    return d[63:32];
            2'd2:    return d[95:64];
            default: return d[127:96];
        endcase
    endfunction

    // Sampled at the falling edge: inputs are stable there and reflect the coming rising edge.
    always @(negedge clk) begin : mon
        logic [34:0] e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got=%h_%h_%b required=none", out_data, out_sel, out_err);
                end else begin
                    e = sb.pop_front();
                    if ({out_data, out_sel, out_err} !== e) begin
                        failures++;
                        $display("FAIL sb_word got=%h_%h_%b required=%h_%h_%b",
                                 out_data, out_sel, out_err, e[34:3], e[2:1], e[0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back({ref_mux(in_data, sel), sel, 1'b0});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [1:0] s);
        for (int i = 0; i < 4; i++) begin
            in_data[i*32 +: 32] = (i == int'(s)) ? d : (~d ^ 32'(i));
        end
        sel = s;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [1:0] s);
        bit got;
        got = 1'b0;
        drive(d, s);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL send_timeout got=not_accepted required=accepted word=%h", d);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && (sb.size() != 0 || out_valid); i++) step();
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s got=pending%0d_valid%b required=pending0_valid0", name, sb.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b required=0", in_ready); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h required=0", out_data); end
        checks++; if (out_sel !== 2'd0 || out_err !== 1'b0) begin failures++; $display("FAIL rst_sel_err got=%h_%b required=0_0", out_sel, out_err); end
        checks++; if (out_valid5 !== 1'b0 || in_ready5 !== 1'b0) begin failures++; $display("FAIL rst_dut5 got=%b%b required=00", out_valid5, in_ready5); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b required=1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(32'hDEADBEEF, 2'd2);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b required=1", out_valid); end
        checks++; if (out_data !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_data got=%h required=deadbeef", out_data); end
        checks++; if (out_sel !== 2'd2 || out_err !== 1'b0) begin failures++; $display("FAIL basic_sel_err got=%h_%b required=2_0", out_sel, out_err); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%b required=0", out_valid); end
    endtask

    task automatic test_sel_range();
        logic [2:0]  tbl [3];
        logic [31:0] exp_d;
        tbl[0] = 3'd7; tbl[1] = 3'd4; tbl[2] = 3'd3;
        out_ready5 = 1'b1;
        for (int i = 0; i < 5; i++) in_data5[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
        foreach (tbl[k]) begin
            sel5 = tbl[k];
            in_valid5 = 1'b1;
            step();
            in_valid5 = 1'b0;
            exp_d = (tbl[k] < 3'd5) ? (32'hA5A5_0000 | 32'(tbl[k])) : 32'h0;
            checks++; if (out_valid5 !== 1'b1) begin failures++; $display("FAIL range_valid sel=%0d got=%b required=1", tbl[k], out_valid5); end
            checks++; if (out_data5 !== exp_d) begin failures++; $display("FAIL range_data sel=%0d got=%h required=%h", tbl[k], out_data5, exp_d); end
            checks++; if (out_err5 !== (tbl[k] >= 3'd5) || out_sel5 !== tbl[k]) begin
                failures++; $display("FAIL range_err sel=%0d got=%b_%0d required=%b_%0d", tbl[k], out_err5, out_sel5, tbl[k] >= 3'd5, tbl[k]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(32'hAAAA_0001, 2'd0);
        in_valid = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hAAAA_0001) begin failures++; $display("FAIL bp_a_out got=%b_%h required=1_aaaa0001", out_valid, out_data); end
        drive(32'hBBBB_0002, 2'd1);
        #1;
        checks++; if (in_ready !== SKID) begin failures++; $display("FAIL bp_ready_after_a got=%b required=%b", in_ready, SKID); end
        step();
        drive(32'hCCCC_0003, 2'd3);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_after_b got=%b required=0", in_ready); end
        step();
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_held got=%b required=0", in_ready); end
        checks++; if (out_data !== 32'hAAAA_0001 || out_sel !== 2'd0) begin failures++; $display("FAIL bp_stable got=%h_%h required=aaaa0001_0", out_data, out_sel); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (!SKID) send_word(32'hBBBB_0002, 2'd1);
        send_word(32'hCCCC_0003, 2'd3);
        wait_drain("bp_drain");
    endtask

    task automatic test_ready_path();
        out_ready = 1'b0;
        drive(32'h1234_5678, 2'd1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== SKID) begin failures++; $display("FAIL path_ready_lo got=%b required=%b", in_ready, SKID); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL path_ready_hi got=%b required=1", in_ready); end
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== SKID) begin failures++; $display("FAIL path_ready_lo2 got=%b required=%b", in_ready, SKID); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL path_drained got=%b required=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(32'h5000_0000 + 32'(i), 2'(i));
            in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got=%b required=1", i, in_ready); end
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid i=%0d got=%b required=1", i, out_valid); end
            end
            step();
        end
        in_valid = 1'b0;
        wait_drain("b2b_drain");
    endtask

    task automatic test_stream();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int w = 0; w < 100; w++) begin
                    repeat ($urandom_range(0, 2)) step();
                    send_word($urandom, 2'($urandom_range(0, 3)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("stream_drain");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_word(32'h0BAD_0001, 2'd1);
        if (SKID) send_word(32'h0BAD_0002, 2'd2);
        rst = 1'b1;
        #1;
        sb.delete();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_async got=%b%b required=00", out_valid, in_ready); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL mid_rst_data got=%h required=0", out_data); end
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_held got=%b%b required=00", out_valid, in_ready); end
        rst = 1'b0;
        out_ready = 1'b1;
        drive(32'h600D_F00D, 2'd3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h600D_F00D) begin failures++; $display("FAIL mid_new_word got=%b_%h required=1_600df00d", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_no_stale got=%b required=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sel_range();
        test_backpressure();
        test_ready_path();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        step();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL final_pending got=%0d required=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_n_1_pipe.md
MUX_N_1_PIPE -- requirements
Module: mux_n_1_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data width of each channel, in bits.
REQ-002 Parameter N, default 4: number of input channels; legal range 2..16.
REQ-003 Localparam SEL_W = max(1, clog2(N)): width of the select field.
REQ-004 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port in_data, input, N*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port sel, input, SEL_W bits: index of the channel to forward, sampled with in_data.
REQ-008 Port in_valid, input, 1 bit: upstream offers in_data and sel this cycle.
REQ-009 Port in_ready, output, 1 bit: the block can accept this cycle.
REQ-010 Port out_data, output, WIDTH bits: the selected channel's data, registered.
REQ-011 Port out_sel, output, SEL_W bits: the sel value that travels with out_data.
REQ-012 Port out_err, output, 1 bit: the sel value that travels with out_data was >= N.
REQ-013 Port out_valid, output, 1 bit: out_data, out_sel and out_err are valid.
REQ-014 Port out_ready, input, 1 bit: downstream accepts this cycle.

Function
REQ-015 Acceptance SHALL occur on any clk edge where in_valid=1 and in_ready=1; transfer out SHALL occur on any edge where out_valid=1 and out_ready=1.
REQ-016 Each accepted word SHALL capture {in_data[sel*WIDTH +: WIDTH], sel, sel>=N}, with zero data substituted when sel>=N.
REQ-017 Latency SHALL be 1 cycle: a word accepted at edge k SHALL appear on out_* after edge k when the block was empty.
REQ-018 Words SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-019 The block SHALL hold a main register and a skid register, tracked by state EMPTY, ONE or TWO.
REQ-020 Transitions from EMPTY: accept -> ONE; otherwise stay in EMPTY.
REQ-021 Transitions from ONE, where drain = out_ready:
- accept & !drain -> TWO (skid loads).
- accept & drain -> ONE (main reloads).
- !accept & drain -> EMPTY.
REQ-022 Transitions from TWO: drain -> ONE with main<=skid; otherwise stay in TWO; no accept is possible.
REQ-023 Output decodes:
- out_valid = (state != EMPTY).
- in_ready = (state != TWO) & !rst.
- in_ready SHALL have no combinational path from out_ready.
REQ-024 out_* SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 in_valid or in_data changing while in_ready=0 SHALL have no effect.

Reset
REQ-026 While rst=1, regardless of clk: state=EMPTY, out_valid=0, out_data=0, out_sel=0, out_err=0, in_ready=0.
REQ-027 Reset asserted mid-transfer SHALL discard the contents of both registers; the first acceptance is possible on the first edge after rst deasserts.

Configuration
REQ-028 Macro MUX_N_1_PIPE_SKID_EN defined: REQ-019..REQ-023 apply (two entries, registered in_ready).
REQ-029 Macro MUX_N_1_PIPE_SKID_EN undefined:
- Single register; states EMPTY and ONE only.
- in_ready = (!out_valid | out_ready) & !rst, which is combinational from out_ready.
- Latency, ordering and reset behaviour are unchanged.

Verification
REQ-030 N=4, WIDTH=32, ch2=0xDEADBEEF, sel=2, one-cycle in_valid, out_ready=1 -> next cycle out_data=0xDEADBEEF, out_sel=2, out_err=0, out_valid=1 for exactly 1 cycle.
REQ-031 N=5, sel=7, ch data nonzero -> out_data=0, out_err=1, out_sel=7.
REQ-032 Skid enabled, out_ready=0, three back-to-back words A,B,C offered:
- A and B accepted; in_ready=0 from the cycle after B is accepted.
- Raise out_ready: A then B then C emerge in order.
REQ-033 Streaming 100 words with random in_valid/out_ready -> scoreboard has zero loss/reorder; in_ready never depends combinationally on out_ready (skid build).
REQ-034 Assert rst for 1 cycle while in TWO -> out_valid=0 and in_ready=0 during reset; the held words are never output; a new word after reset emerges with 1-cycle latency.
REQ-035 Skid disabled, out_valid=1, out_ready toggled -> in_ready follows out_ready in the same cycle; throughput is 1 word/cycle with out_ready=1.
